pcs_tx_scrambler_gearbox: RTL and testbench

PCS_TX_SCRAMBLER_GEARBOX -- requirements
Module: pcs_tx_scrambler_gearbox

---
 rtl/pcs_tx_scrambler_gearbox.sv | 84 ++++++++
 tb/tb_pcs_tx_scrambler_gearbox.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_scrambler_gearbox.sv
// 64b/66b PCS transmit path: self-synchronising x^58+x^39+1 payload scrambler
// feeding a 66-to-DATA_WIDTH bit gearbox; bit 0 is always transmitted first.
module pcs_tx_scrambler_gearbox #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter bit          SCRAMBLE_EN = 1'b1,
  parameter logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [63:0]           i_tx_data,
  input  logic [1:0]            i_tx_header,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_underflow
);

  localparam int unsigned BufW = DATA_WIDTH + 66;
  localparam int unsigned OccW = $clog2(DATA_WIDTH + 66);
  localparam logic [OccW-1:0] WordOcc = OccW'(DATA_WIDTH);
  localparam logic [OccW-1:0] BlkOcc  = OccW'(66);

  logic [BufW-1:0] gbox_q, gbox_d, shifted, blk_ext;
  logic [OccW-1:0] occ_q, occ_d, occ_rem;
  logic [57:0]     scr_q, scr_d;
  logic [63:0]     payload;
  logic            started_q;
  logic            fire, accept;

  // Ready depends only on registered state; gated low while reset is held.
  always_comb begin
    fire       = (occ_q >= WordOcc);
    occ_rem    = fire ? (occ_q - WordOcc) : occ_q;
    o_tx_ready = !i_reset && (occ_rem < WordOcc);
    accept     = i_tx_valid && o_tx_ready;
  end

  always_comb begin
    scr_d   = scr_q;
    payload = i_tx_data;
    if (SCRAMBLE_EN) begin
      for (int i = 0; i < 64; i++) begin
        payload[i] = i_tx_data[i] ^ scr_d[38] ^ scr_d[57];
        scr_d      = {scr_d[56:0], payload[i]};
      end
    end
  end

  // Bits above occ are always zero, so the append can simply be OR-ed in.
  always_comb begin
    shifted = fire ? (gbox_q >> DATA_WIDTH) : gbox_q;
    blk_ext = BufW'({payload, i_tx_header});
    gbox_d  = shifted;
    occ_d   = occ_rem;
    if (accept) begin
      gbox_d = shifted | (blk_ext << occ_rem);
      occ_d  = occ_rem + BlkOcc;
    end
  end

  always_comb begin
    o_tx_valid  = fire;
    o_tx_data   = fire ? gbox_q[DATA_WIDTH-1:0] : '0;
    o_underflow = started_q && !fire;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gbox_q    <= '0;
      occ_q     <= '0;
      scr_q     <= SCR_SEED;
      started_q <= 1'b0;
    end else begin
      gbox_q    <= gbox_d;
      occ_q     <= occ_d;
      started_q <= started_q | fire;
      if (accept && SCRAMBLE_EN) begin
        scr_q <= scr_d;
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_scrambler_gearbox.sv
// Bench for pcs_tx_scrambler_gearbox: a scrambled 64-bit and a bypassed 32-bit instance
// share one stimulus stream; a bit-queue scoreboard predicts every output word.
module tb_pcs_tx_scrambler_gearbox;

  localparam logic [57:0] Seed = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tx_data;
  logic [1:0]  tx_header;
  logic        tx_valid;
  logic        rdy64, vld64, unf64;
  logic [63:0] data64;
  logic        rdy32, vld32, unf32;
  logic [31:0] data32;

  int n_checks = 0;
  int n_pass   = 0;

  bit          q64[$];
  bit          q32[$];
  logic [57:0] scr_m;
  bit          st64, st32;
  logic [63:0] w64, p64;
  logic [31:0] w32;
  bit          ev64, ev32;

  always #5 clk = ~clk;

  pcs_tx_scrambler_gearbox u_dut64 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_tx_data   (tx_data),
    .i_tx_header (tx_header),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (rdy64),
    .o_tx_data   (data64),
    .o_tx_valid  (vld64),
    .o_underflow (unf64)
  );

  pcs_tx_scrambler_gearbox #(
    .DATA_WIDTH  (32),
    .SCRAMBLE_EN (1'b0)
  ) u_dut32 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_tx_data   (tx_data),
    .i_tx_header (tx_header),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (rdy32),
    .o_tx_data   (data32),
    .o_tx_valid  (vld32),
    .o_underflow (unf32)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_val);
    n_checks++;
    if (act !== exp_val) $display("FAIL %s: got %h expected %h", tag, act, exp_val);
    else n_pass++;
  endtask

  function automatic logic [63:0] scramble(input logic [63:0] d, input logic [57:0] st,
                                           output logic [57:0] st_o);
    logic [63:0] s;
    logic [57:0] t;
    t = st;
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ t[38] ^ t[57];
      t    = {t[56:0], s[i]};
    end
    st_o = t;
    return s;
  endfunction

  // Scoreboard: pop the word due this cycle, then append any block accepted at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      ev64 = (q64.size() >= 64);
      check("valid64", {63'd0, vld64}, {63'd0, ev64});
      check("underflow64", {63'd0, unf64}, {63'd0, st64 && !ev64});
      if (ev64) begin
        for (int i = 0; i < 64; i++) w64[i] = q64.pop_front();
        check("data64", data64, w64);
        st64 = 1'b1;
      end else begin
        check("idle_data64", data64, 64'd0);
      end

      ev32 = (q32.size() >= 32);
      check("valid32", {63'd0, vld32}, {63'd0, ev32});
      check("underflow32", {63'd0, unf32}, {63'd0, st32 && !ev32});
      if (ev32) begin
        for (int i = 0; i < 32; i++) w32[i] = q32.pop_front();
        check("data32", {32'd0, data32}, {32'd0, w32});
        st32 = 1'b1;
      end else begin
        check("idle_data32", {32'd0, data32}, 64'd0);
      end

      if (tx_valid && rdy64) begin
        p64 = scramble(tx_data, scr_m, scr_m);
        q64.push_back(tx_header[0]);
        q64.push_back(tx_header[1]);
        for (int i = 0; i < 64; i++) q64.push_back(p64[i]);
      end
      if (tx_valid && rdy32) begin
        q32.push_back(tx_header[0]);
        q32.push_back(tx_header[1]);
        for (int i = 0; i < 64; i++) q32.push_back(tx_data[i]);
      end
    end
  end

  // mode 0: continuous valid, 1: idle, 2: valid only while the 64-bit instance is not ready
  task automatic drive(input int mode);
    @(posedge clk);
    #1;
    tx_data   = {$urandom, $urandom};
    tx_header = 2'($urandom_range(0, 3));
    case (mode)
      0:       tx_valid = 1'b1;
      1:       tx_valid = 1'b0;
      default: tx_valid = !rdy64;
    endcase
  endtask

  task automatic model_reset();
    q64.delete();
    q32.delete();
    scr_m = Seed;
    st64  = 1'b0;
    st32  = 1'b0;
  endtask

  int lows, gaps, unf32_cnt;

  initial begin
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_header = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready64", {63'd0, rdy64}, 64'd0);
    check("rst_valid64", {63'd0, vld64}, 64'd0);
    check("rst_data64", data64, 64'd0);
    check("rst_underflow64", {63'd0, unf64}, 64'd0);
    check("rst_ready32", {63'd0, rdy32}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("release_ready64", {63'd0, rdy64}, 64'd1);
    check("release_ready32", {63'd0, rdy32}, 64'd1);

    // Continuous traffic: ready64 low once per 33 cycles, no output gaps after the first.
    lows = 0;
    gaps = 0;
    unf32_cnt = 0;
    for (int c = 0; c <= 330; c++) begin
      drive(0);
      if (c > 0 && !rdy64) lows++;
      if (c > 0 && !vld64) gaps++;
      if (unf32) unf32_cnt++;
    end
    check("ready_low_per_330", 64'(lows), 64'd10);
    check("valid_gaps64", 64'(gaps), 64'd0);
    check("underflow32_cnt", 64'(unf32_cnt), 64'd0);

    // Starvation after 10 more blocks.
    repeat (10) drive(0);
    repeat (3) drive(1);
    repeat (20) drive(0);

    // Back-pressure: valid only offered while the 64-bit side is full.
    repeat (40) drive(2);
    repeat (40) drive(0);

    // Reset in the middle of a block; outputs must clear without waiting for an edge.
    repeat (7) drive(0);
    #2 rst = 1'b1;
    tx_valid = 1'b0;
    #1;
    check("midrst_valid64", {63'd0, vld64}, 64'd0);
    check("midrst_data64", data64, 64'd0);
    check("midrst_ready64", {63'd0, rdy64}, 64'd0);
    check("midrst_underflow64", {63'd0, unf64}, 64'd0);
    check("midrst_data32", {32'd0, data32}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_release_ready64", {63'd0, rdy64}, 64'd1);
    repeat (100) drive(0);
    repeat (5) drive(1);
    @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
